// File: rtl/demux8_stream.sv
// 1-to-2 stream demultiplexer: each accepted input byte lands in the one-entry
// output register of channel A or B, chosen by s or by a round-robin pointer.
module demux8_stream #(
  parameter int WIDTH = 8,
  parameter int CNTW  = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             s,
  input  logic             mode,
  output logic [WIDTH-1:0] a_data,
  output logic             a_valid,
  input  logic             a_ready,
  output logic [WIDTH-1:0] b_data,
  output logic             b_valid,
  input  logic             b_ready,
  output logic [CNTW-1:0]  cnt_a,
  output logic [CNTW-1:0]  cnt_b
);

  // Handshake: a transfer happens on a rising edge where valid && ready; the
  // producer holds data/valid until then, and ready never waits on valid.

  localparam logic [CNTW-1:0] CNT_ONE = {{(CNTW-1){1'b0}}, 1'b1};

  logic rr;
  logic dest;
  logic dest_valid;
  logic dest_ready;
  logic accept;
  logic load_a;
  logic load_b;
  logic a_fire;
  logic b_fire;

  always_comb begin
    dest       = mode ? rr : s;
    dest_valid = dest ? b_valid : a_valid;
    dest_ready = dest ? b_ready : a_ready;
  end

  // A full register still accepts when it is draining on the same edge.
  assign in_ready = !dest_valid || dest_ready;
  assign accept   = in_valid && in_ready;
  assign load_a   = accept && !dest;
  assign load_b   = accept && dest;
  assign a_fire   = a_valid && a_ready;
  assign b_fire   = b_valid && b_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_data  <= '0;
      a_valid <= 1'b0;
      b_data  <= '0;
      b_valid <= 1'b0;
      cnt_a   <= '0;
      cnt_b   <= '0;
      rr      <= 1'b0;
    end else begin
      if (load_a) begin
        a_data  <= in_data;
        a_valid <= 1'b1;
      end else if (a_fire) begin
        a_valid <= 1'b0;
      end

      if (load_b) begin
        b_data  <= in_data;
        b_valid <= 1'b1;
      end else if (b_fire) begin
        b_valid <= 1'b0;
      end

      if (a_fire) cnt_a <= cnt_a + CNT_ONE;
      if (b_fire) cnt_b <= cnt_b + CNT_ONE;

      // The pointer only advances on a real round-robin accept.
      if (accept && mode) rr <= ~rr;
    end
  end

endmodule

// File: doc/demux8_stream.md
Name: demux8_stream

Overview:
- 1-to-2 stream demultiplexer: the inverse of the 8-bit 2:1 mux.
- Accepts one byte per cycle on a single valid/ready input and routes it to output channel A or B.
- Each channel has its own one-entry output register and valid/ready handshake.
- Destination comes from an explicit select bit or an internal round-robin pointer; per-channel transfer counters support debug and bench checking.

Parameters:
WIDTH, 8, data width of input and both output channels
CNTW, 8, width of per-channel transfer counters (wrap-around)

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
in_data  input  WIDTH  input byte
in_valid  input  1  in_data valid
in_ready  output  1  block can accept in_data this cycle
s  input  1  destination select when mode=0: 0 -> A, 1 -> B
mode  input  1  0 = route by s, 1 = round-robin A,B,A,B...
a_data  output  WIDTH  channel A data register
a_valid  output  1  channel A holds data
a_ready  input  1  channel A consumer ready
b_data  output  WIDTH  channel B data register
b_valid  output  1  channel B holds data
b_ready  input  1  channel B consumer ready
cnt_a  output  CNTW  completed A output transfers (a_valid && a_ready)
cnt_b  output  CNTW  completed B output transfers

Behaviour:
- Reset (rst_n=0, asynchronous, any time):
  - a_data, b_data, cnt_a, cnt_b = 0; a_valid, b_valid = 0; round-robin pointer rr = 0 (A).
  - Data held in either register is discarded.
  - in_ready is combinational and follows the reset register values.
- Destination: dest = mode ? rr : s, combinational, re-evaluated every cycle.
- in_ready = !dest_valid || dest_ready, combinational, where dest_valid/dest_ready belong to the channel selected by dest.
- Accept = in_valid && in_ready. On accept, at the next rising edge:
  - dest_data <= in_data and dest_valid <= 1.
  - Input-to-output latency is exactly 1 cycle.
- Drain: at the edge where x_valid && x_ready, x_valid <= 0 unless the same edge loads a new accept into x.
  - Simultaneous drain and fill: new data loaded, x_valid stays 1. Full throughput of 1 byte/cycle per channel is sustained.
- The non-destination channel is unaffected by an accept; it drains independently.
- x_data holds its value while x_valid=1 && x_ready=0. After drain, x_data keeps its last value; only x_valid is meaningful.
- rr toggles only on an accept while mode=1.
  - rr does not change while mode=0 or on a stalled cycle.
  - Switching mode from 0 to 1 resumes from the current rr.
- cnt_x increments by 1 on each output transfer of channel x, wrapping 2^CNTW-1 -> 0.
- Upstream rule: in_data, s and mode are held stable while in_valid=1 and in_ready=0. Behaviour with s or mode = x is undefined; the bench does not check it.
- Only edges of clk change state. There are no combinational paths from in_data to the outputs.

Test Plan:
- Select by s, mode=0, both ready=1:
  - in_data=8'b11110000, s=0, valid for 1 cycle -> next cycle a_valid=1, a_data=11110000, b_valid=0, cnt_a=1 one edge later.
  - Then 8'b00001111 with s=1 -> b_data=00001111, cnt_b=1.
- Backpressure:
  - a_ready=0; send 8'b10000000 to A -> a_valid=1.
  - Next byte 8'b00000001 to A -> in_ready=0, a_data stays 10000000.
  - Raise a_ready -> one edge later a_data=00000001. cnt_a increments per handshake.
- Blocked channel does not block the other:
  - A full and stalled, s=1, in_data=8'hAA -> in_ready=1; b_data=8'hAA next cycle, A unchanged.
- Round-robin, mode=1, both ready, 6 consecutive bytes 1..6:
  - A receives 1,3,5; B receives 2,4,6.
  - A stall on byte 3 holds rr at A until accepted.
- Counter wrap: with CNTW=8, complete 256 transfers on A -> cnt_a returns to 0; cnt_b = 0 throughout.
- Reset mid-operation:
  - Both channels valid with a_ready=b_ready=0; assert rst_n=0 between clock edges.
  - Immediately a_valid=b_valid=0, counters=0, in_ready=1.
  - After release, the first mode=1 byte goes to A.
